// File: rtl/sort3_pkg.sv
// Shared widths and round-robin pointer helper for the sort3 arbiter slice.
package sort3_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned TRIPLE_W = 3 * BYTE_W;

  // Pointer moves one past the granted requester, wrapping at nreq.
  function automatic int unsigned next_rr(input int unsigned grant_idx, input int unsigned nreq);
    return (grant_idx + 32'd1 >= nreq) ? 32'd0 : grant_idx + 32'd1;
  endfunction

endpackage

// File: rtl/sort3_stage.sv
// Sorter stage: registers a raw triple with its pairwise compare flags,
// then picks largest/middle/smallest from those flags.
module sort3_stage
  import sort3_pkg::*;
#(
  parameter int unsigned IDW = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic                adv_i,
  input  logic [TRIPLE_W-1:0] triple_i,
  input  logic [IDW-1:0]      id_i,
  output logic                valid_o,
  output logic [BYTE_W-1:0]   l_o,
  output logic [BYTE_W-1:0]   m_o,
  output logic [BYTE_W-1:0]   s_o,
  output logic [IDW-1:0]      id_o
);

  logic              valid_q, valid_d;
  logic [BYTE_W-1:0] a_q, b_q, c_q;
  logic              ab_q, bc_q, ca_q;
  logic [IDW-1:0]    id_q;

  // A same-cycle load wins over the advance that empties the stage.
  assign valid_d = load_i | (valid_q & ~adv_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      ab_q    <= 1'b0;
      bc_q    <= 1'b0;
      ca_q    <= 1'b0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      if (load_i) begin
        a_q  <= triple_i[2*BYTE_W +: BYTE_W];
        b_q  <= triple_i[BYTE_W +: BYTE_W];
        c_q  <= triple_i[0 +: BYTE_W];
        ab_q <= triple_i[2*BYTE_W +: BYTE_W] > triple_i[BYTE_W +: BYTE_W];
        bc_q <= triple_i[BYTE_W +: BYTE_W] > triple_i[0 +: BYTE_W];
        ca_q <= triple_i[0 +: BYTE_W] > triple_i[2*BYTE_W +: BYTE_W];
        id_q <= id_i;
      end
    end
  end

  assign l_o     = ab_q ? (ca_q ? c_q : a_q) : (bc_q ? b_q : c_q);
  assign m_o     = ab_q ? (bc_q ? b_q : (ca_q ? a_q : c_q)) : (bc_q ? (ca_q ? c_q : a_q) : b_q);
  assign s_o     = ab_q ? (bc_q ? c_q : b_q) : (ca_q ? a_q : c_q);
  assign valid_o = valid_q;
  assign id_o    = id_q;

endmodule

// File: rtl/sort3_arbiter.sv
// Round-robin front end sharing one two-stage 3-byte sorter between NREQ
// requesters; results leave on one valid/ready port tagged with requester ID.
module sort3_arbiter
  import sort3_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [TRIPLE_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W-1:0]        out_L,
  output logic [BYTE_W-1:0]        out_M,
  output logic [BYTE_W-1:0]        out_S,
  output logic [IDW-1:0]           out_id,
  output logic                     busy
);

  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic                out_valid_q, out_valid_d;
  logic [BYTE_W-1:0]   out_l_q, out_l_d, out_m_q, out_m_d, out_s_q, out_s_d;
  logic [IDW-1:0]      out_id_q, out_id_d;

  logic                s1_valid, s2_free_c, s1_adv_c, can_accept_c, hs_c;
  logic                found_c;
  logic [IDW-1:0]      grant_idx_c;
  logic [BYTE_W-1:0]   st_l, st_m, st_s;
  logic [IDW-1:0]      st_id;
  logic [TRIPLE_W-1:0] trip_c [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_trip
    assign trip_c[g] = req_data[g*TRIPLE_W +: TRIPLE_W];
  end

  assign s2_free_c    = !out_valid_q || out_ready;
  assign s1_adv_c     = s1_valid && s2_free_c;
  assign can_accept_c = !s1_valid || s1_adv_c;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int unsigned idx;
    found_c     = 1'b0;
    grant_idx_c = '0;
    idx         = 32'd0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found_c && req_valid[IDW'(idx)]) begin
        found_c     = 1'b1;
        grant_idx_c = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (can_accept_c && found_c) req_ready[grant_idx_c] = 1'b1;
  end

  assign hs_c     = |req_ready;
  assign rr_ptr_d = hs_c ? IDW'(next_rr(32'(grant_idx_c), NREQ)) : rr_ptr_q;

  sort3_stage #(.IDW(IDW)) u_stage (
    .clk      (clk),
    .rst      (rst),
    .load_i   (hs_c),
    .adv_i    (s1_adv_c),
    .triple_i (trip_c[grant_idx_c]),
    .id_i     (grant_idx_c),
    .valid_o  (s1_valid),
    .l_o      (st_l),
    .m_o      (st_m),
    .s_o      (st_s),
    .id_o     (st_id)
  );

  // Output register: refilled from S1 whenever it drains or is empty.
  always_comb begin
    out_valid_d = out_valid_q;
    out_l_d     = out_l_q;
    out_m_d     = out_m_q;
    out_s_d     = out_s_q;
    out_id_d    = out_id_q;
    if (s1_adv_c) begin
      out_valid_d = 1'b1;
      out_l_d     = st_l;
      out_m_d     = st_m;
      out_s_d     = st_s;
      out_id_d    = st_id;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_l_q     <= '0;
      out_m_q     <= '0;
      out_s_q     <= '0;
      out_id_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_l_q     <= out_l_d;
      out_m_q     <= out_m_d;
      out_s_q     <= out_s_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_L     = out_l_q;
  assign out_M     = out_m_q;
  assign out_S     = out_s_q;
  assign out_id    = out_id_q;
  assign busy      = s1_valid || out_valid_q;

endmodule

// File: tb/tb_sort3_arbiter.sv
// Bench for sort3_arbiter: directed scenarios plus randomized traffic checked
// every cycle against an item-level model that sorts by plain comparison.
module tb_sort3_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [24*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_L, out_M, out_S;
  logic [IDW-1:0]    out_id;
  logic              busy;
  logic [23:0]       req_tri [NREQ];

  int errors = 0;
  int checks = 0;

  assign req_data = {req_tri[3], req_tri[2], req_tri[1], req_tri[0]};

  always #5 clk = ~clk;

  sort3_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_L     (out_L),
    .out_M     (out_M),
    .out_S     (out_S),
    .out_id    (out_id),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Descending bubble sort of the three bytes, returned as {L,M,S}.
  function automatic logic [23:0] sorted(input logic [23:0] t);
    logic [7:0] v [3];
    logic [7:0] tmp;
    v[0] = t[23:16];
    v[1] = t[15:8];
    v[2] = t[7:0];
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2 - i; j++)
        if (v[j] < v[j+1]) begin
          tmp = v[j]; v[j] = v[j+1]; v[j+1] = tmp;
        end
    return {v[0], v[1], v[2]};
  endfunction

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 0; k < int'(NREQ); k++) begin
      int i;
      i = (ptr + k) % int'(NREQ);
      if (v[IDW'(i)]) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 4))
      0:       return 8'd0;
      1:       return 8'd255;
      2:       return 8'($urandom_range(0, 2));
      default: return 8'($urandom);
    endcase
  endfunction

  // Model: item sitting in the sorter, item presented at the output, pointer.
  bit              started = 1'b0;
  bit              m_s1v, m_ov;
  logic [23:0]     m_s1, m_o;
  int              m_s1id, m_oid, m_ptr;
  logic [NREQ-1:0] hs_mask = '0;

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    int g;
    bit free, adv, can;
    if (started) begin
      free = !m_ov || out_ready;
      adv  = m_s1v && free;
      can  = !m_s1v || adv;
      g    = rr_pick(m_ptr, req_valid);
      exp_rdy = '0;
      if (can && g >= 0) exp_rdy[IDW'(g)] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("busy", 32'(busy), 32'(m_s1v || m_ov));
      if (m_ov) begin
        chk("out_L", 32'(out_L), 32'(m_o[23:16]));
        chk("out_M", 32'(out_M), 32'(m_o[15:8]));
        chk("out_S", 32'(out_S), 32'(m_o[7:0]));
        chk("out_id", 32'(out_id), 32'(m_oid));
      end
      hs_mask = req_ready & req_valid;
      if (rst) begin
        m_s1v = 1'b0;
        m_ov  = 1'b0;
        m_ptr = 0;
      end else begin
        if (adv) begin
          m_o = m_s1; m_oid = m_s1id; m_ov = 1'b1;
        end else if (out_ready) begin
          m_ov = 1'b0;
        end
        if (can && g >= 0) begin
          m_s1   = sorted(req_tri[IDW'(g)]);
          m_s1id = g;
          m_s1v  = 1'b1;
          m_ptr  = (g + 1) % int'(NREQ);
        end else if (adv) begin
          m_s1v = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [23:0] tin [4];
    logic [23:0] texp [4];
    tin[0] = {8'd255, 8'd0, 8'd255}; texp[0] = {8'd255, 8'd255, 8'd0};
    tin[1] = {8'd7, 8'd7, 8'd7};     texp[1] = {8'd7, 8'd7, 8'd7};
    tin[2] = {8'd0, 8'd1, 8'd2};     texp[2] = {8'd2, 8'd1, 8'd0};
    tin[3] = {8'd2, 8'd1, 8'd0};     texp[3] = {8'd2, 8'd1, 8'd0};

    rst = 1'b1; req_valid = '0; out_ready = 1'b1;
    for (int i = 0; i < int'(NREQ); i++) req_tri[i] = '0;
    tick(); tick();
    started = 1'b1;
    rst = 1'b0;

    // Reset state and a single triple through the pipe.
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_L", 32'(out_L), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    req_valid = 4'b0001; req_tri[0] = {8'd30, 8'd10, 8'd20};
    @(negedge clk);
    chk("t1_grant", 32'(req_ready), 32'd1);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t1_not_yet", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_L", 32'(out_L), 32'd30);
    chk("t1_M", 32'(out_M), 32'd20);
    chk("t1_S", 32'(out_S), 32'd10);
    chk("t1_id", 32'(out_id), 32'd0);

    // All requesters streaming: grants rotate, one result per cycle.
    tick(); rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 4'hF;
    for (int i = 0; i < int'(NREQ); i++) req_tri[i] = {3{8'(i)}};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t2_grant", 32'(req_ready), 32'(1 << (k % 4)));
      if (k >= 2) begin
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_id", 32'(out_id), 32'((k - 2) % 4));
      end
      tick();
    end

    // Downstream stall with both stages full, then drain in order.
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("t3_stall_ready", 32'(req_ready), 32'd0);
      chk("t3_hold_id", 32'(out_id), 32'd0);
      chk("t3_hold_L", 32'(out_L), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("t3_drain_valid", 32'(out_valid), 32'd1);
      chk("t3_drain_id", 32'(out_id), 32'(r));
      tick();
    end

    // Edge and tie values, one at a time from requester 0.
    req_valid = '0; rst = 1'b1; tick(); rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      req_valid = 4'b0001; req_tri[0] = tin[t];
      tick();
      req_valid = '0;
      tick();
      @(negedge clk);
      chk("t4_valid", 32'(out_valid), 32'd1);
      chk("t4_LMS", 32'({out_L, out_M, out_S}), 32'(texp[t]));
      tick();
    end

    // Reset while both stages hold data.
    out_ready = 1'b0; req_valid = 4'hF;
    tick(); tick();
    @(negedge clk);
    chk("t5_full_valid", 32'(out_valid), 32'd1);
    chk("t5_full_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b1; req_valid = 4'b0110;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_grant", 32'(req_ready), 32'b0010);
    tick();

    // Lone requester 2: pointer wraps past 3 back onto it.
    req_valid = 4'b0100;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("t6_grant", 32'(req_ready), 32'b0100);
      tick();
    end

    // Randomized traffic; data only changes when a requester is free to.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (hs_mask[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_tri[i]   = {rand_byte(), rand_byte(), rand_byte()};
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end

    rst = 1'b0; req_valid = '0; out_ready = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    started = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
